psa_share_arbiter: RTL and testbench

//  - Shares one PSA_16bit instance between two requesters, e.g. the execute stage and a vector/test port.
//    PSA_16bit is a 4x4-bit sub-word adder.
//  - Arbitrates the two requesters, registers the winner's operands and sequences one add.
//  - Returns the registered sum and overflow flag to the winner.
//  - Sits between the requesters and the PSA datapath; the PSA adder itself stays combinational.

---
 rtl/psa_share_arbiter.sv | 159 +++++++++++++++
 tb/tb_psa_share_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/psa_share_arbiter.sv
// psa_share_arbiter: lets two requesters share one PSA_16bit sub-word adder.
// A 3-state FSM (IDLE -> EXEC -> RESP) picks a winner and latches its operands.
// It then registers the nibble-wise sum and overflow, and reports them with a
// one-cycle done pulse.
// Optional feature macro: PSA_PERF_EN adds saturating per-requester grant
// counters (cnt0_o, cnt1_o, width CNT_W).

// Combinational PSA_16bit: four independent 4-bit adds, no carry between nibbles
module psa_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum,
  output logic        ovfl
);

  logic [3:0] nib_ovf;

  for (genvar k = 0; k < 4; k++) begin : g_nib
    logic [3:0] s;
    assign s              = a[4*k +: 4] + b[4*k +: 4];
    assign sum[4*k +: 4]  = s;
    // signed 4-bit overflow: operands agree in sign, result disagrees
    assign nib_ovf[k]     = (a[4*k+3] == b[4*k+3]) && (s[3] != a[4*k+3]);
  end

  assign ovfl = |nib_ovf;

endmodule

module psa_share_arbiter #(
  parameter int FIXED_PRI = 0
`ifdef PSA_PERF_EN
  ,
  parameter int CNT_W     = 16
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_i,
  input  logic [15:0] a0_i,
  input  logic [15:0] b0_i,
  input  logic [15:0] a1_i,
  input  logic [15:0] b1_i,
  output logic [1:0]  gnt_o,
  output logic [1:0]  done_o,
  output logic [15:0] sum_o,
  output logic        ovfl_o,
  output logic        busy_o
`ifdef PSA_PERF_EN
  ,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        id;
  logic        rr;
  logic        win;
  logic        take;
  logic [15:0] psa_sum;
  logic        psa_ovfl;

  // The single shared adder always sees the latched operands of the current winner
  psa_16bit u_psa (
    .a    (op_a),
    .b    (op_b),
    .sum  (psa_sum),
    .ovfl (psa_ovfl)
  );

  assign take = (req_i != 2'b00);

  // Winner: a lone requester wins outright; a tie goes to requester 0 or the rr pointer
  always_comb begin
    win = 1'b0;
    case (req_i)
      2'b10:   win = 1'b1;
      2'b11:   win = (FIXED_PRI != 0) ? 1'b0 : rr;
      default: win = 1'b0;
    endcase
  end

  // Main sequencer: latch winner in IDLE, grant+compute in EXEC, report in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      id     <= 1'b0;
      rr     <= 1'b0;
      gnt_o  <= 2'b00;
      done_o <= 2'b00;
      sum_o  <= '0;
      ovfl_o <= 1'b0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done_o <= 2'b00;
          if (take) begin
            op_a   <= win ? a1_i : a0_i;
            op_b   <= win ? b1_i : b0_i;
            id     <= win;
            gnt_o  <= {win, ~win};
            busy_o <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt_o  <= 2'b00;
          sum_o  <= psa_sum;
          ovfl_o <= psa_ovfl;
          done_o <= {id, ~id};
          state  <= RESP;
        end
        RESP: begin
          done_o <= 2'b00;
          busy_o <= 1'b0;
          if (FIXED_PRI == 0) begin
            rr <= ~id;
          end
          state  <= IDLE;
        end
        default: begin
          gnt_o  <= 2'b00;
          done_o <= 2'b00;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

`ifdef PSA_PERF_EN
  // Grant counters bump on the same edge that raises gnt_o and stick at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt0_o <= '0;
      cnt1_o <= '0;
    end else if (state == IDLE && take) begin
      if (!win) begin
        if (cnt0_o != {CNT_W{1'b1}}) cnt0_o <= cnt0_o + 1'b1;
      end else begin
        if (cnt1_o != {CNT_W{1'b1}}) cnt1_o <= cnt1_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_psa_share_arbiter.sv
// Directed testbench for psa_share_arbiter.
// u_rr is round-robin and u_fp is fixed-priority; both share one stimulus.
// With PSA_PERF_EN, u_sat adds CNT_W=2 to exercise counter saturation.
module tb_psa_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req;
  logic [15:0] a0, b0, a1, b1;

  logic [1:0]  gnt_rr, done_rr, gnt_fp, done_fp;
  logic [15:0] sum_rr, sum_fp;
  logic        ovfl_rr, ovfl_fp, busy_rr, busy_fp;

  int n_checks;
  int n_fail;

`ifdef PSA_PERF_EN
  logic [15:0] cnt0_rr, cnt1_rr, cnt0_fp, cnt1_fp;
  logic [1:0]  gnt_sat, done_sat, cnt0_sat, cnt1_sat;
  logic [15:0] sum_sat;
  logic        ovfl_sat, busy_sat;
`endif

  psa_share_arbiter #(.FIXED_PRI(0)) u_rr (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .a0_i   (a0),
    .b0_i   (b0),
    .a1_i   (a1),
    .b1_i   (b1),
    .gnt_o  (gnt_rr),
    .done_o (done_rr),
    .sum_o  (sum_rr),
    .ovfl_o (ovfl_rr),
    .busy_o (busy_rr)
`ifdef PSA_PERF_EN
    ,
    .cnt0_o (cnt0_rr),
    .cnt1_o (cnt1_rr)
`endif
  );

  psa_share_arbiter #(.FIXED_PRI(1)) u_fp (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .a0_i   (a0),
    .b0_i   (b0),
    .a1_i   (a1),
    .b1_i   (b1),
    .gnt_o  (gnt_fp),
    .done_o (done_fp),
    .sum_o  (sum_fp),
    .ovfl_o (ovfl_fp),
    .busy_o (busy_fp)
`ifdef PSA_PERF_EN
    ,
    .cnt0_o (cnt0_fp),
    .cnt1_o (cnt1_fp)
`endif
  );

`ifdef PSA_PERF_EN
  psa_share_arbiter #(.FIXED_PRI(0), .CNT_W(2)) u_sat (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (req),
    .a0_i   (a0),
    .b0_i   (b0),
    .a1_i   (a1),
    .b1_i   (b1),
    .gnt_o  (gnt_sat),
    .done_o (done_sat),
    .sum_o  (sum_sat),
    .ovfl_o (ovfl_sat),
    .busy_o (busy_sat),
    .cnt0_o (cnt0_sat),
    .cnt1_o (cnt1_sat)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something stalls the sequence
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Presents a single request with operands for the chosen requester
  task automatic start_op(input logic [1:0] r, input logic [15:0] a, input logic [15:0] b);
    req = r;
    if (r[0]) begin a0 = a; b0 = b; end
    if (r[1]) begin a1 = a; b1 = b; end
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    req   = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req = 2'b00; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt_rr); end
    n_checks++; if (done_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_done: got %b want 00", done_rr); end
    n_checks++; if (sum_rr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_sum: got %h want 0000", sum_rr); end
    n_checks++; if (ovfl_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ovfl: got %b want 0", ovfl_rr); end
    n_checks++; if (busy_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b want 0", busy_rr); end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b00 || busy_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL idle_no_req: got gnt=%b busy=%b want 00/0", gnt_rr, busy_rr); end
  endtask

  task automatic test_basic();
    start_op(2'b01, 16'h1234, 16'h1111);
    @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b01) begin n_fail++; $display("[TB] FAIL basic_gnt: got %b want 01", gnt_rr); end
    n_checks++; if (busy_rr !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_busy_exec: got %b want 1", busy_rr); end
    n_checks++; if (done_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL basic_done_early: got %b want 00", done_rr); end
    req = 2'b00;
    a0 = 16'hDEAD;
    @(negedge clk);
    n_checks++; if (done_rr !== 2'b01) begin n_fail++; $display("[TB] FAIL basic_done: got %b want 01", done_rr); end
    n_checks++; if (sum_rr !== 16'h2345) begin n_fail++; $display("[TB] FAIL basic_sum: got %h want 2345", sum_rr); end
    n_checks++; if (ovfl_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_ovfl: got %b want 0", ovfl_rr); end
    n_checks++; if (gnt_rr !== 2'b00 || busy_rr !== 1'b1) begin n_fail++; $display("[TB] FAIL basic_resp: got gnt=%b busy=%b want 00/1", gnt_rr, busy_rr); end
    @(negedge clk);
    n_checks++; if (done_rr !== 2'b00 || busy_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_idle: got done=%b busy=%b want 00/0", done_rr, busy_rr); end
    n_checks++; if (sum_rr !== 16'h2345) begin n_fail++; $display("[TB] FAIL basic_sum_hold: got %h want 2345", sum_rr); end
  endtask

  task automatic test_overflow();
    start_op(2'b10, 16'h7000, 16'h1000);
    @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_gnt: got %b want 10", gnt_rr); end
    req = 2'b00;
    @(negedge clk);
    n_checks++; if (done_rr !== 2'b10) begin n_fail++; $display("[TB] FAIL ovf_done: got %b want 10", done_rr); end
    n_checks++; if (sum_rr !== 16'h8000) begin n_fail++; $display("[TB] FAIL ovf_sum: got %h want 8000", sum_rr); end
    n_checks++; if (ovfl_rr !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_flag: got %b want 1", ovfl_rr); end
    @(negedge clk);
  endtask

  task automatic test_nibble_wrap();
    logic [15:0] va [4];
    logic [15:0] vb [4];
    logic [15:0] vs [4];
    logic        vo [4];
    va[0] = 16'hFFFF; vb[0] = 16'h0001; vs[0] = 16'hFFF0; vo[0] = 1'b0;
    va[1] = 16'h8888; vb[1] = 16'h8888; vs[1] = 16'h0000; vo[1] = 1'b1;
    va[2] = 16'h5A3C; vb[2] = 16'h3B7D; vs[2] = 16'h85A9; vo[2] = 1'b1;
    va[3] = 16'h1234; vb[3] = 16'h4321; vs[3] = 16'h5555; vo[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_op(2'b01, va[i], vb[i]);
      @(negedge clk);
      req = 2'b00;
      @(negedge clk);
      n_checks++; if (sum_rr !== vs[i]) begin n_fail++; $display("[TB] FAIL wrap_sum[%0d]: got %h want %h", i, sum_rr, vs[i]); end
      n_checks++; if (ovfl_rr !== vo[i]) begin n_fail++; $display("[TB] FAIL wrap_ovfl[%0d]: got %b want %b", i, ovfl_rr, vo[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0]  exp_gnt;
    logic [15:0] exp_sum;
    reset_pulse();
    req = 2'b11;
    a0 = 16'h1111; b0 = 16'h1111;
    a1 = 16'h2222; b1 = 16'h2222;
    for (int i = 0; i < 4; i++) begin
      exp_gnt = (i % 2 == 1) ? 2'b10 : 2'b01;
      exp_sum = (i % 2 == 1) ? 16'h4444 : 16'h2222;
      @(negedge clk);
      n_checks++; if (gnt_rr !== exp_gnt) begin n_fail++; $display("[TB] FAIL rr_gnt[%0d]: got %b want %b", i, gnt_rr, exp_gnt); end
      n_checks++; if (gnt_fp !== 2'b01) begin n_fail++; $display("[TB] FAIL fp_gnt[%0d]: got %b want 01", i, gnt_fp); end
      n_checks++; if (busy_fp !== 1'b1) begin n_fail++; $display("[TB] FAIL fp_busy[%0d]: got %b want 1", i, busy_fp); end
      @(negedge clk);
      n_checks++; if (done_rr !== exp_gnt) begin n_fail++; $display("[TB] FAIL rr_done[%0d]: got %b want %b", i, done_rr, exp_gnt); end
      n_checks++; if (sum_rr !== exp_sum) begin n_fail++; $display("[TB] FAIL rr_sum[%0d]: got %h want %h", i, sum_rr, exp_sum); end
      n_checks++; if (sum_fp !== 16'h2222 || ovfl_fp !== 1'b0) begin n_fail++; $display("[TB] FAIL fp_result[%0d]: got %h/%b want 2222/0", i, sum_fp, ovfl_fp); end
      @(negedge clk);
    end
    req = 2'b00;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    start_op(2'b01, 16'h1234, 16'h1111);
    @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_gnt_before: got %b want 01", gnt_rr); end
    req = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_gnt_clear: got %b want 00", gnt_rr); end
    n_checks++; if (done_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_done_clear: got %b want 00", done_rr); end
    n_checks++; if (sum_rr !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_sum_clear: got %h want 0000", sum_rr); end
    n_checks++; if (busy_rr !== 1'b0) begin n_fail++; $display("[TB] FAIL mid_busy_clear: got %b want 0", busy_rr); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++; if (done_rr !== 2'b00) begin n_fail++; $display("[TB] FAIL mid_no_done[%0d]: got %b want 00", i, done_rr); end
    end
    start_op(2'b01, 16'h1234, 16'h1111);
    @(negedge clk);
    n_checks++; if (gnt_rr !== 2'b01) begin n_fail++; $display("[TB] FAIL mid_after_gnt: got %b want 01", gnt_rr); end
    req = 2'b00;
    @(negedge clk);
    n_checks++; if (done_rr !== 2'b01 || sum_rr !== 16'h2345) begin n_fail++; $display("[TB] FAIL mid_after_result: got %b/%h want 01/2345", done_rr, sum_rr); end
    @(negedge clk);
  endtask

`ifdef PSA_PERF_EN
  // Single request, then drop it and let the operation finish
  task automatic run_op(input logic [1:0] r);
    req = r;
    @(negedge clk);
    req = 2'b00;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_perf_counters();
    reset_pulse();
    for (int i = 0; i < 5; i++) begin
      run_op((i % 2 == 1) ? 2'b10 : 2'b01);
    end
    n_checks++; if (cnt0_rr !== 16'd3) begin n_fail++; $display("[TB] FAIL perf_cnt0: got %0d want 3", cnt0_rr); end
    n_checks++; if (cnt1_rr !== 16'd2) begin n_fail++; $display("[TB] FAIL perf_cnt1: got %0d want 2", cnt1_rr); end
    n_checks++; if (cnt0_sat !== 2'd3 || cnt1_sat !== 2'd2) begin n_fail++; $display("[TB] FAIL perf_sat_mid: got %0d/%0d want 3/2", cnt0_sat, cnt1_sat); end
    run_op(2'b01);
    run_op(2'b01);
    n_checks++; if (cnt0_rr !== 16'd5) begin n_fail++; $display("[TB] FAIL perf_cnt0_more: got %0d want 5", cnt0_rr); end
    n_checks++; if (cnt0_sat !== 2'd3) begin n_fail++; $display("[TB] FAIL perf_sat_hold: got %0d want 3", cnt0_sat); end
    n_checks++; if (cnt0_fp !== 16'd5 || cnt1_fp !== 16'd2) begin n_fail++; $display("[TB] FAIL perf_fp_cnt: got %0d/%0d want 5/2", cnt0_fp, cnt1_fp); end
  endtask
`endif

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_overflow();
    test_nibble_wrap();
    test_round_robin();
    test_reset_mid();
`ifdef PSA_PERF_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
